// File: rtl/lifo_mc_pkg.sv
// Shared definitions for the multi-channel LIFO: default sizes, the occupancy
// type, the per-channel flag bundle and the helpers that size and derive them.
package lifo_mc_pkg;

  localparam int DEF_DWIDTH   = 16;
  localparam int DEF_AWIDTH   = 8;
  localparam int DEF_CHANNELS = 4;

  // Fill level for the default depth; it needs one bit more than the address
  // so that a completely full stack (2**AWIDTH words) can be represented.
  typedef logic [DEF_AWIDTH:0] usedw_t;

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } flags_t;

  // A channel selector is always at least one bit wide, even for one channel.
  function automatic int calc_chw(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int calc_depth(input int awidth);
    return 1 << awidth;
  endfunction

  // All four flags depend only on the fill level, so they are computed from
  // the next fill level and registered alongside it.
  function automatic flags_t calc_flags(input int unsigned used,
                                        input int unsigned depth,
                                        input int unsigned ae_value,
                                        input int unsigned af_value);
    flags_t f;
    f              = '0;
    f.empty        = (used == 0);
    f.full         = (used == depth);
    f.almost_empty = (used < ae_value);
    f.almost_full  = (used >= af_value);
    return f;
  endfunction

endpackage

// File: rtl/lifo_mc_if.sv
// Request/response bundle of the multi-channel LIFO. The master side issues
// pushes and pops; the slave side (the LIFO) returns popped data and status.
// Optional error ports appear when LIFO_MC_ERR_EN is defined.
interface lifo_mc_if
  import lifo_mc_pkg::*;
#(
  parameter int DWIDTH   = DEF_DWIDTH,
  parameter int AWIDTH   = DEF_AWIDTH,
  parameter int CHANNELS = DEF_CHANNELS
);

  localparam int CHW = calc_chw(CHANNELS);

  logic                           wrreq;
  logic [CHW-1:0]                 wr_ch;
  logic [DWIDTH-1:0]              data;
  logic                           rdreq;
  logic [CHW-1:0]                 rd_ch;
  logic [DWIDTH-1:0]              q;
  logic                           q_valid;
  logic [CHW-1:0]                 q_ch;
  logic [CHANNELS*(AWIDTH+1)-1:0] usedw;
  logic [CHANNELS-1:0]            empty;
  logic [CHANNELS-1:0]            full;
  logic [CHANNELS-1:0]            almost_empty;
  logic [CHANNELS-1:0]            almost_full;
`ifdef LIFO_MC_ERR_EN
  logic                           err_clr;
  logic [CHANNELS-1:0]            overflow;
  logic [CHANNELS-1:0]            underflow;
`endif

  modport master (
    output wrreq, wr_ch, data, rdreq, rd_ch,
`ifdef LIFO_MC_ERR_EN
    output err_clr,
    input  overflow, underflow,
`endif
    input  q, q_valid, q_ch, usedw, empty, full, almost_empty, almost_full
  );

  modport slave (
    input  wrreq, wr_ch, data, rdreq, rd_ch,
`ifdef LIFO_MC_ERR_EN
    input  err_clr,
    output overflow, underflow,
`endif
    output q, q_valid, q_ch, usedw, empty, full, almost_empty, almost_full
  );

endinterface

// File: rtl/lifo_mc_ram.sv
// Simple dual-port storage shared by all stacks: one write port, one read port
// with a registered output. On a same-address collision the read returns the
// old contents. Only the output register is reset; the array is not cleared.
module lifo_mc_ram #(
  parameter int DWIDTH = 16,
  parameter int AW     = 10,
  parameter int WORDS  = 1024
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [WORDS];

  // Write port: store the pushed word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: output register loads only on a read, so it holds between pops.
  always_ff @(posedge clk) begin
    if (!srst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/lifo_mc.sv
// Multi-channel LIFO: CHANNELS independent stacks of 2**AWIDTH words carved
// out of one shared RAM (channel number forms the upper address bits).
// One push and one pop per cycle, to any channels. Defining LIFO_MC_ERR_EN
// adds sticky per-channel overflow/underflow flags with a clear input.
module lifo_mc
  import lifo_mc_pkg::*;
#(
  parameter int DWIDTH             = DEF_DWIDTH,
  parameter int AWIDTH             = DEF_AWIDTH,
  parameter int CHANNELS           = DEF_CHANNELS,
  parameter int ALMOST_EMPTY_VALUE = 2,
  parameter int ALMOST_FULL_VALUE  = 254
) (
  input logic     clk,
  input logic     srst,
  lifo_mc_if.slave bus
);

  localparam int CHW    = calc_chw(CHANNELS);
  localparam int DEPTH  = calc_depth(AWIDTH);
  localparam int RAM_AW = CHW + AWIDTH;

  logic [AWIDTH:0]   usedw_r   [CHANNELS];
  logic [AWIDTH:0]   usedw_nxt [CHANNELS];
  flags_t            flags_r   [CHANNELS];

  logic              wr_ch_ok;
  logic              rd_ch_ok;
  logic              same_ch;
  logic              pop_ok;
  logic              push_ok;
  logic [AWIDTH:0]   wr_level;
  logic [AWIDTH:0]   rd_level;
  logic [AWIDTH-1:0] widx;
  logic [AWIDTH-1:0] ridx;
  logic [RAM_AW-1:0] waddr;
  logic [RAM_AW-1:0] raddr;
  logic [DWIDTH-1:0] ram_q;
  logic              q_valid_r;
  logic [CHW-1:0]    q_ch_r;

  // Decide which requests are accepted and where they hit the RAM. A push to a
  // full stack is still taken when the same stack is popped in that cycle: the
  // new word replaces the top slot being read out, so the level never exceeds
  // the depth.
  always_comb begin
    wr_ch_ok = (int'(bus.wr_ch) < CHANNELS);
    rd_ch_ok = (int'(bus.rd_ch) < CHANNELS);
    wr_level = wr_ch_ok ? usedw_r[bus.wr_ch] : '0;
    rd_level = rd_ch_ok ? usedw_r[bus.rd_ch] : '0;
    same_ch  = (bus.wr_ch == bus.rd_ch);
    pop_ok   = srst && bus.rdreq && rd_ch_ok && !flags_r[bus.rd_ch].empty;
    push_ok  = srst && bus.wrreq && wr_ch_ok &&
               (!flags_r[bus.wr_ch].full || (pop_ok && same_ch));
    widx     = wr_level[AWIDTH-1:0];
    if (pop_ok && same_ch) begin
      widx = wr_level[AWIDTH-1:0] - 1'b1;
    end
    ridx  = rd_level[AWIDTH-1:0] - 1'b1;
    waddr = {bus.wr_ch, widx};
    raddr = {bus.rd_ch, ridx};
  end

  // Next fill level per channel; a push and a pop on one channel cancel out.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      usedw_nxt[c] = usedw_r[c];
      if (push_ok && (bus.wr_ch == CHW'(c))) begin
        usedw_nxt[c] = usedw_nxt[c] + 1'b1;
      end
      if (pop_ok && (bus.rd_ch == CHW'(c))) begin
        usedw_nxt[c] = usedw_nxt[c] - 1'b1;
      end
    end
  end

  // Fill levels and their flags update together on every edge.
  always_ff @(posedge clk) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (!srst) begin
        usedw_r[c] <= '0;
        flags_r[c] <= calc_flags(0, DEPTH, ALMOST_EMPTY_VALUE, ALMOST_FULL_VALUE);
      end else begin
        usedw_r[c] <= usedw_nxt[c];
        flags_r[c] <= calc_flags(32'(usedw_nxt[c]), DEPTH,
                                 ALMOST_EMPTY_VALUE, ALMOST_FULL_VALUE);
      end
    end
  end

  // Pop result tag: valid pulses for one cycle, channel holds with the data.
  always_ff @(posedge clk) begin
    if (!srst) begin
      q_valid_r <= 1'b0;
      q_ch_r    <= '0;
    end else begin
      q_valid_r <= pop_ok;
      if (pop_ok) begin
        q_ch_r <= bus.rd_ch;
      end
    end
  end

  lifo_mc_ram #(
    .DWIDTH (DWIDTH),
    .AW     (RAM_AW),
    .WORDS  (CHANNELS * DEPTH)
  ) u_ram (
    .clk   (clk),
    .srst  (srst),
    .we    (push_ok),
    .waddr (waddr),
    .wdata (bus.data),
    .re    (pop_ok),
    .raddr (raddr),
    .rdata (ram_q)
  );

  // Drive the status bundle from the registered state.
  always_comb begin
    bus.q            = ram_q;
    bus.q_valid      = q_valid_r;
    bus.q_ch         = q_ch_r;
    bus.usedw        = '0;
    bus.empty        = '0;
    bus.full         = '0;
    bus.almost_empty = '0;
    bus.almost_full  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      bus.usedw[c*(AWIDTH+1) +: (AWIDTH+1)] = usedw_r[c];
      bus.empty[c]        = flags_r[c].empty;
      bus.full[c]         = flags_r[c].full;
      bus.almost_empty[c] = flags_r[c].almost_empty;
      bus.almost_full[c]  = flags_r[c].almost_full;
    end
  end

`ifdef LIFO_MC_ERR_EN
  logic [CHANNELS-1:0] overflow_r;
  logic [CHANNELS-1:0] underflow_r;

  // Sticky error bits; a new error wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!srst) begin
      overflow_r  <= '0;
      underflow_r <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        overflow_r[c]  <= (overflow_r[c] && !bus.err_clr) ||
                          (bus.wrreq && !push_ok && (bus.wr_ch == CHW'(c)));
        underflow_r[c] <= (underflow_r[c] && !bus.err_clr) ||
                          (bus.rdreq && !pop_ok && (bus.rd_ch == CHW'(c)));
      end
    end
  end

  assign bus.overflow  = overflow_r;
  assign bus.underflow = underflow_r;
`endif

endmodule

// File: tb/tb_lifo_mc.sv
// Directed bench for lifo_mc with default parameters (4 channels, 256 deep).
// Expected values are hand-derived; error-flag checks exist with LIFO_MC_ERR_EN.
module tb_lifo_mc;
  import lifo_mc_pkg::*;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int CH = 4;

  logic clk;
  logic srst;
  int   checks;
  int   errors;

  lifo_mc_if #(.DWIDTH(DW), .AWIDTH(AW), .CHANNELS(CH)) bus ();

  lifo_mc #(
    .DWIDTH             (DW),
    .AWIDTH             (AW),
    .CHANNELS           (CH),
    .ALMOST_EMPTY_VALUE (2),
    .ALMOST_FULL_VALUE  (254)
  ) dut (
    .clk  (clk),
    .srst (srst),
    .bus  (bus)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] time limit reached");
  end

  function automatic usedw_t get_used(input int c);
    return bus.usedw[c*(AW+1) +: (AW+1)];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Present one cycle of requests, let the edge take them, then idle the bus.
  task automatic applyStimulus(input logic wr, input logic [1:0] wch,
                               input logic [15:0] d, input logic rd,
                               input logic [1:0] rch);
    bus.wrreq = wr;
    bus.wr_ch = wch;
    bus.data  = d;
    bus.rdreq = rd;
    bus.rd_ch = rch;
    @(posedge clk);
    #1;
    bus.wrreq = 1'b0;
    bus.rdreq = 1'b0;
  endtask

  task automatic do_reset();
    srst = 1'b0;
    @(posedge clk);
    #1;
    srst = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    srst      = 1'b0;
    bus.wrreq = 1'b0;
    bus.wr_ch = '0;
    bus.data  = '0;
    bus.rdreq = 1'b0;
    bus.rd_ch = '0;
`ifdef LIFO_MC_ERR_EN
    bus.err_clr = 1'b0;
`endif

    do_reset();
    checkOutput("rst_usedw", 32'(bus.usedw), 32'h0);
    checkOutput("rst_empty", 32'(bus.empty), 32'hF);
    checkOutput("rst_full", 32'(bus.full), 32'h0);
    checkOutput("rst_aempty", 32'(bus.almost_empty), 32'hF);
    checkOutput("rst_afull", 32'(bus.almost_full), 32'h0);
    checkOutput("rst_qvalid", 32'(bus.q_valid), 32'h0);
    checkOutput("rst_q", 32'(bus.q), 32'h0);

    // Channel 1: three pushes then three pops in reverse order.
    applyStimulus(1'b1, 2'd1, 16'h00A1, 1'b0, 2'd0);
    applyStimulus(1'b1, 2'd1, 16'h00A2, 1'b0, 2'd0);
    applyStimulus(1'b1, 2'd1, 16'h00A3, 1'b0, 2'd0);
    checkOutput("ch1_used3", 32'(get_used(1)), 32'd3);
    checkOutput("ch1_notempty", 32'(bus.empty), 32'hD);
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd1);
    checkOutput("ch1_pop1_q", 32'(bus.q), 32'hA3);
    checkOutput("ch1_pop1_v", 32'(bus.q_valid), 32'h1);
    checkOutput("ch1_pop1_ch", 32'(bus.q_ch), 32'h1);
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd1);
    checkOutput("ch1_pop2_q", 32'(bus.q), 32'hA2);
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd1);
    checkOutput("ch1_pop3_q", 32'(bus.q), 32'hA1);
    checkOutput("ch1_used0", 32'(get_used(1)), 32'd0);
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b0, 2'd0);
    checkOutput("idle_qvalid", 32'(bus.q_valid), 32'h0);
    checkOutput("idle_qhold", 32'(bus.q), 32'hA1);

    // Channel 0: fill to the top and probe the threshold flags on the way.
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 2'd0, 16'(i), 1'b0, 2'd0);
      if (i == 252) checkOutput("ch0_253_afull", 32'(bus.almost_full[0]), 32'h0);
      if (i == 253) begin
        checkOutput("ch0_254_afull", 32'(bus.almost_full[0]), 32'h1);
        checkOutput("ch0_254_full", 32'(bus.full[0]), 32'h0);
      end
    end
    checkOutput("ch0_full", 32'(bus.full[0]), 32'h1);
    checkOutput("ch0_used256", 32'(get_used(0)), 32'd256);
    applyStimulus(1'b1, 2'd0, 16'hFFFF, 1'b0, 2'd0);
    checkOutput("ch0_ovf_used", 32'(get_used(0)), 32'd256);
`ifdef LIFO_MC_ERR_EN
    checkOutput("ch0_ovf_flag", 32'(bus.overflow), 32'h1);
`endif
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd0);
    checkOutput("ch0_top_q", 32'(bus.q), 32'h00FF);
    checkOutput("ch0_top_full", 32'(bus.full[0]), 32'h0);
    applyStimulus(1'b1, 2'd0, 16'h1234, 1'b0, 2'd0);
    applyStimulus(1'b1, 2'd0, 16'hBEEF, 1'b1, 2'd0);
    checkOutput("ch0_fullswap_q", 32'(bus.q), 32'h1234);
    checkOutput("ch0_fullswap_used", 32'(get_used(0)), 32'd256);
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd0);
    checkOutput("ch0_after_swap_q", 32'(bus.q), 32'hBEEF);
`ifdef LIFO_MC_ERR_EN
    bus.err_clr = 1'b1;
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b0, 2'd0);
    checkOutput("errclr_ovf", 32'(bus.overflow), 32'h0);
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd3);
    checkOutput("errclr_and_unf", 32'(bus.underflow), 32'h8);
    bus.err_clr = 1'b0;
`endif
    do_reset();
    checkOutput("rst2_usedw", 32'(bus.usedw), 32'h0);

    // Channel 2: push and pop together returns the old top, new word stays.
    applyStimulus(1'b1, 2'd2, 16'h0011, 1'b0, 2'd0);
    applyStimulus(1'b1, 2'd2, 16'h0022, 1'b0, 2'd0);
    applyStimulus(1'b1, 2'd2, 16'h0033, 1'b1, 2'd2);
    checkOutput("ch2_swap_q", 32'(bus.q), 32'h22);
    checkOutput("ch2_swap_used", 32'(get_used(2)), 32'd2);
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd2);
    checkOutput("ch2_pop_new", 32'(bus.q), 32'h33);
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd2);
    checkOutput("ch2_pop_old", 32'(bus.q), 32'h11);
    checkOutput("ch2_empty", 32'(bus.empty[2]), 32'h1);

    // Cross-channel traffic: pop of an empty stack rejected, push proceeds.
    applyStimulus(1'b1, 2'd0, 16'h0055, 1'b1, 2'd3);
    checkOutput("x_used0", 32'(get_used(0)), 32'd1);
    checkOutput("x_qvalid", 32'(bus.q_valid), 32'h0);
`ifdef LIFO_MC_ERR_EN
    checkOutput("x_unf3", 32'(bus.underflow), 32'h8);
`endif
    applyStimulus(1'b1, 2'd1, 16'h0077, 1'b1, 2'd0);
    checkOutput("x2_q", 32'(bus.q), 32'h55);
    checkOutput("x2_qch", 32'(bus.q_ch), 32'h0);
    checkOutput("x2_used1", 32'(get_used(1)), 32'd1);
    checkOutput("x2_used0", 32'(get_used(0)), 32'd0);

    // Same channel, empty: only the push lands.
    applyStimulus(1'b1, 2'd3, 16'h0099, 1'b1, 2'd3);
    checkOutput("ch3_empty_swap_v", 32'(bus.q_valid), 32'h0);
    checkOutput("ch3_used1", 32'(get_used(3)), 32'd1);
    checkOutput("ch3_aempty1", 32'(bus.almost_empty[3]), 32'h1);
    applyStimulus(1'b1, 2'd3, 16'h00AA, 1'b0, 2'd0);
    checkOutput("ch3_aempty2", 32'(bus.almost_empty[3]), 32'h0);

    // Reset right after an accepted pop discards its result.
    applyStimulus(1'b0, 2'd0, 16'h0, 1'b1, 2'd3);
    checkOutput("pre_rst_q", 32'(bus.q), 32'hAA);
    checkOutput("pre_rst_v", 32'(bus.q_valid), 32'h1);
    do_reset();
    checkOutput("mid_rst_v", 32'(bus.q_valid), 32'h0);
    checkOutput("mid_rst_empty", 32'(bus.empty), 32'hF);
    checkOutput("mid_rst_usedw", 32'(bus.usedw), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
